// File: rtl/instruction_serializer.sv
// Serializes one 24-bit instruction into a valid/ready byte stream, MSB byte first.
// The length comes from bits [23:22] of the first byte (code + 1 bytes); code 3 is dropped with an err pulse.
module instruction_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] in_opcode,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        err
);
   localparam int unsigned WORD_W    = 8;
   localparam int unsigned MAX_WORDS = 3;
   localparam int unsigned OP_W      = WORD_W * MAX_WORDS;
   localparam int unsigned IDX_W     = 2;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     opcode_q, opcode_d;
   logic [IDX_W-1:0]    len_q, len_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   out_byte_q, out_byte_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                err_q, err_d;

   logic                in_fire;
   logic                out_fire;
   logic [IDX_W-1:0]    len_code;
   logic                code_legal;
   logic [IDX_W-1:0]    idx_nxt;

   assign len_code   = in_opcode[OP_W-1 -: IDX_W];
   assign code_legal = (len_code != 2'd3);
   assign out_fire   = out_valid_q & out_ready;
   assign in_ready   = ~rst & ((state_q == IDLE) | (out_fire & out_last_q));
   assign in_fire    = in_valid & in_ready;
   assign idx_nxt    = IDX_W'(idx_q + 2'd1);

   // Next-state and output-register computation
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      len_d       = len_q;
      idx_d       = idx_q;
      out_byte_d  = out_byte_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_fire) begin
               if (code_legal) begin
                  opcode_d    = in_opcode;
                  len_d       = IDX_W'(len_code + 2'd1);
                  idx_d       = '0;
                  out_valid_d = 1'b1;
                  out_byte_d  = in_opcode[OP_W-1 -: WORD_W];
                  out_last_d  = (len_code == 2'd0);
                  state_d     = SEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (out_fire) begin
               if (!out_last_q) begin
                  idx_d       = idx_nxt;
                  out_byte_d  = (idx_nxt == 2'd1) ? opcode_q[15:8] : opcode_q[7:0];
                  out_last_d  = (idx_nxt == IDX_W'(len_q - 2'd1));
               end else if (in_fire && code_legal) begin
                  // Reload on the final beat so back-to-back instructions have no bubble
                  opcode_d    = in_opcode;
                  len_d       = IDX_W'(len_code + 2'd1);
                  idx_d       = '0;
                  out_valid_d = 1'b1;
                  out_byte_d  = in_opcode[OP_W-1 -: WORD_W];
                  out_last_d  = (len_code == 2'd0);
               end else begin
                  err_d       = in_fire;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         opcode_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         out_byte_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         out_byte_q  <= out_byte_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign out_byte  = out_byte_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == SEND);
   assign err       = err_q;

endmodule
